// File: rtl/store_buffer_pkg.sv
// Shared memory-stage types for the store buffer: entry payload, drain state and address limit.
package mem_pkg;

   localparam int unsigned TAG_W              = 32;
   localparam int unsigned ADDR_W             = 32;
   localparam int unsigned DATA_W             = 32;
   localparam int unsigned ADDR_LIMIT_DEFAULT = 2048;

   typedef struct packed {
      logic              valid;
      logic              committed;
      logic [TAG_W-1:0]  inst_num;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_REQ  = 1'b1
   } sb_state_e;

endpackage

// File: rtl/store_buffer_age_sel.sv
// Combinational DEPTH-way age selector: index of the min or max tag among masked entries.
module store_buffer_age_sel
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic                        find_max,
   input  logic [DEPTH-1:0]            mask,
   input  logic [DEPTH-1:0][TAG_W-1:0] tags,
   output logic                        found,
   output logic [IDX_W-1:0]            idx
);

   logic [TAG_W-1:0] best;

   // Strict compare keeps the lowest index on equal tags.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      best  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (mask[i] && (!found || (find_max ? (tags[i] > best) : (tags[i] < best)))) begin
            found = 1'b1;
            idx   = IDX_W'(i);
            best  = tags[i];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Speculative store buffer: holds executed stores, commits on ROB retire, drains in tag order,
// forwards to younger loads. Define STORE_ADDR_CHECK_EN to add the store address range check.
module store_buffer
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
`ifdef STORE_ADDR_CHECK_EN
   parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT,
`endif
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exception_sig,
   input  logic              mret_sig,
   input  logic              memwrite,
   input  logic [TAG_W-1:0]  inst_num,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] store_data,
   input  logic              commit_valid,
   input  logic [TAG_W-1:0]  inst_num_rob,
   input  logic [ADDR_W-1:0] mem_addr_rob,
   input  logic              ld_query,
   input  logic [TAG_W-1:0]  ld_inst_num,
   input  logic [ADDR_W-1:0] ld_address,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef STORE_ADDR_CHECK_EN
   output logic              store_address_exception,
`endif
   output logic              sb_full,
   output logic              sb_empty
);

   sb_entry_t [DEPTH-1:0] entries_q, entries_d;
   sb_state_e             state_q, state_d;
   logic [IDX_W-1:0]      drain_idx_q, drain_idx_d;
   logic                  mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  fwd_hit_q, fwd_hit_d;
   logic [DATA_W-1:0]     fwd_data_q, fwd_data_d;
   logic                  sb_full_q, sb_full_d;
   logic                  sb_empty_q, sb_empty_d;

   logic                        flush_c;
   logic                        addr_ok_c;
   logic                        enq_ok_c;
   logic                        enq_commit_c;
   logic                        drain_done_c;
   logic                        free_found_c;
   logic [IDX_W-1:0]            free_idx_c;
   logic [DEPTH-1:0]            drain_mask_c;
   logic [DEPTH-1:0]            fwd_mask_c;
   logic [DEPTH-1:0][TAG_W-1:0] tags_c;
   logic [DEPTH-1:0]            valid_d_c;
   logic                        drain_found_c;
   logic [IDX_W-1:0]            drain_sel_c;
   logic                        fwd_found_c;
   logic [IDX_W-1:0]            fwd_sel_c;

   assign flush_c      = exception_sig | mret_sig;
   assign enq_ok_c     = memwrite & ~sb_full_q & ~flush_c & addr_ok_c & free_found_c;
   assign enq_commit_c = commit_valid && (inst_num == inst_num_rob) && (address == mem_addr_rob);

`ifdef STORE_ADDR_CHECK_EN
   logic store_address_exception_q, store_address_exception_d;

   assign addr_ok_c                 = (address <= ADDR_W'(ADDR_LIMIT));
   assign store_address_exception_d = memwrite & ~addr_ok_c;
   assign store_address_exception   = store_address_exception_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) store_address_exception_q <= 1'b0;
      else       store_address_exception_q <= store_address_exception_d;
   end
`else
   assign addr_ok_c = 1'b1;
`endif

   // Lowest-index free slot for allocation.
   always_comb begin
      free_found_c = 1'b0;
      free_idx_c   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!free_found_c && !entries_q[i].valid) begin
            free_found_c = 1'b1;
            free_idx_c   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         tags_c[i]       = entries_q[i].inst_num;
         drain_mask_c[i] = entries_q[i].valid & entries_q[i].committed;
         fwd_mask_c[i]   = entries_q[i].valid && (entries_q[i].address == ld_address) &&
                           (entries_q[i].inst_num < ld_inst_num);
      end
   end

   store_buffer_age_sel #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_drain_sel (
      .find_max (1'b0),
      .mask     (drain_mask_c),
      .tags     (tags_c),
      .found    (drain_found_c),
      .idx      (drain_sel_c)
   );

   store_buffer_age_sel #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fwd_sel (
      .find_max (1'b1),
      .mask     (fwd_mask_c),
      .tags     (tags_c),
      .found    (fwd_found_c),
      .idx      (fwd_sel_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= SB_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_IDLE: if (drain_found_c) state_d = SB_REQ;
         SB_REQ:  if (mem_req_ready) state_d = SB_IDLE;
      endcase
   end

   // Drain request outputs are latched on issue and held until accepted.
   always_comb begin
      drain_idx_d     = drain_idx_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      drain_done_c    = 1'b0;
      case (state_q)
         SB_IDLE: begin
            if (drain_found_c) begin
               drain_idx_d     = drain_sel_c;
               mem_req_valid_d = 1'b1;
               mem_addr_d      = entries_q[drain_sel_c].address;
               mem_wdata_d     = entries_q[drain_sel_c].data;
            end
         end
         SB_REQ: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               drain_done_c    = 1'b1;
            end
         end
      endcase
   end

   // Commit is applied before the flush clear so a same-cycle commit survives.
   always_comb begin
      entries_d = entries_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (commit_valid && entries_q[i].valid && (entries_q[i].inst_num == inst_num_rob) &&
             (entries_q[i].address == mem_addr_rob)) begin
            entries_d[i].committed = 1'b1;
         end
      end
      if (flush_c) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!entries_d[i].committed) entries_d[i].valid = 1'b0;
         end
      end
      if (drain_done_c) begin
         entries_d[drain_idx_q].valid     = 1'b0;
         entries_d[drain_idx_q].committed = 1'b0;
      end
      if (enq_ok_c) begin
         entries_d[free_idx_c] = '{valid:     1'b1,
                                   committed: enq_commit_c,
                                   inst_num:  inst_num,
                                   address:   address,
                                   data:      store_data};
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) valid_d_c[i] = entries_d[i].valid;
      sb_full_d  = &valid_d_c;
      sb_empty_d = ~|valid_d_c;
   end

   always_comb begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = fwd_data_q;
      if (!flush_c && ld_query && fwd_found_c) begin
         fwd_hit_d  = 1'b1;
         fwd_data_d = entries_q[fwd_sel_c].data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entries_q       <= '0;
         drain_idx_q     <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         fwd_hit_q       <= 1'b0;
         fwd_data_q      <= '0;
         sb_full_q       <= 1'b0;
         sb_empty_q      <= 1'b1;
      end else begin
         entries_q       <= entries_d;
         drain_idx_q     <= drain_idx_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         fwd_hit_q       <= fwd_hit_d;
         fwd_data_q      <= fwd_data_d;
         sb_full_q       <= sb_full_d;
         sb_empty_q      <= sb_empty_d;
      end
   end

   assign fwd_hit       = fwd_hit_q;
   assign fwd_data      = fwd_data_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign sb_full       = sb_full_q;
   assign sb_empty      = sb_empty_q;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a behavioural entry-table model plus directed scenarios.
module tb_store_buffer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        exception_sig, mret_sig, memwrite, commit_valid, ld_query, mem_req_ready;
   logic [31:0] inst_num, address, store_data, inst_num_rob, mem_addr_rob, ld_inst_num, ld_address;
   logic        fwd_hit, mem_req_valid, sb_full, sb_empty;
   logic [31:0] fwd_data, mem_addr, mem_wdata;
`ifdef STORE_ADDR_CHECK_EN
   logic        store_address_exception;
`endif

   store_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .exception_sig (exception_sig),
      .mret_sig      (mret_sig),
      .memwrite      (memwrite),
      .inst_num      (inst_num),
      .address       (address),
      .store_data    (store_data),
      .commit_valid  (commit_valid),
      .inst_num_rob  (inst_num_rob),
      .mem_addr_rob  (mem_addr_rob),
      .ld_query      (ld_query),
      .ld_inst_num   (ld_inst_num),
      .ld_address    (ld_address),
      .fwd_hit       (fwd_hit),
      .fwd_data      (fwd_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
`ifdef STORE_ADDR_CHECK_EN
      .store_address_exception (store_address_exception),
`endif
      .sb_full       (sb_full),
      .sb_empty      (sb_empty)
   );

   always #5 clk = ~clk;

   // Model: table of stores plus the expected registered outputs.
   logic        m_valid[DEPTH], m_comm[DEPTH];
   logic [31:0] m_tag[DEPTH], m_addr[DEPTH], m_data[DEPTH];
   logic        m_busy, m_req, m_hit, m_full, m_empty, m_exc;
   int          m_didx;
   logic [31:0] m_maddr, m_mwdata, m_fdata;

   int          checks = 0;
   int          errors = 0;
   logic        prev_req = 1'b0;
   logic [31:0] drained[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0; m_comm[i] = 1'b0;
         m_tag[i] = '0; m_addr[i] = '0; m_data[i] = '0;
      end
      m_busy = 0; m_req = 0; m_hit = 0; m_full = 0; m_empty = 1; m_exc = 0;
      m_didx = 0; m_maddr = '0; m_mwdata = '0; m_fdata = '0;
   endtask

   task automatic model_step();
      logic flush, addr_ok;
      logic nv[DEPTH], nc[DEPTH];
      int   best, sel, free_i, cnt;
      flush = exception_sig | mret_sig;
`ifdef STORE_ADDR_CHECK_EN
      addr_ok = (address <= 32'd2048);
      m_exc   = memwrite && !addr_ok;
`else
      addr_ok = 1'b1;
`endif
      // youngest older store to the same address
      best = -1;
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i] && m_addr[i] == ld_address && m_tag[i] < ld_inst_num &&
             (best < 0 || m_tag[i] > m_tag[best])) best = i;
      sel = -1;
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i] && m_comm[i] && (sel < 0 || m_tag[i] < m_tag[sel])) sel = i;
      free_i = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) free_i = i;

      for (int i = 0; i < DEPTH; i++) begin
         nv[i] = m_valid[i];
         nc[i] = m_comm[i] | (commit_valid && m_valid[i] && m_tag[i] == inst_num_rob &&
                              m_addr[i] == mem_addr_rob);
         if (flush && !nc[i]) nv[i] = 1'b0;
      end
      if (m_busy) begin
         if (mem_req_ready) begin
            nv[m_didx] = 0; nc[m_didx] = 0; m_busy = 0; m_req = 0;
         end
      end else if (sel >= 0) begin
         m_busy = 1; m_req = 1; m_didx = sel; m_maddr = m_addr[sel]; m_mwdata = m_data[sel];
      end
      if (flush) m_hit = 0;
      else if (ld_query && best >= 0) begin m_hit = 1; m_fdata = m_data[best]; end
      else m_hit = 0;
      if (memwrite && !m_full && !flush && addr_ok && free_i >= 0) begin
         nv[free_i] = 1;
         nc[free_i] = commit_valid && inst_num == inst_num_rob && address == mem_addr_rob;
         m_tag[free_i] = inst_num; m_addr[free_i] = address; m_data[free_i] = store_data;
      end
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = nv[i]; m_comm[i] = nc[i];
         if (nv[i]) cnt++;
      end
      m_full  = (cnt == DEPTH);
      m_empty = (cnt == 0);
   endtask

   task automatic compare();
      chk("fwd_hit", {31'b0, fwd_hit}, {31'b0, m_hit});
      chk("fwd_data", fwd_data, m_fdata);
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, m_req});
      chk("mem_addr", mem_addr, m_maddr);
      chk("mem_wdata", mem_wdata, m_mwdata);
      chk("sb_full", {31'b0, sb_full}, {31'b0, m_full});
      chk("sb_empty", {31'b0, sb_empty}, {31'b0, m_empty});
`ifdef STORE_ADDR_CHECK_EN
      chk("store_address_exception", {31'b0, store_address_exception}, {31'b0, m_exc});
`endif
      if (mem_req_valid && !prev_req) drained.push_back(mem_wdata);
      prev_req = mem_req_valid;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      exception_sig = 0; mret_sig = 0; memwrite = 0; commit_valid = 0; ld_query = 0;
      inst_num = '0; address = '0; store_data = '0; inst_num_rob = '0; mem_addr_rob = '0;
      ld_inst_num = '0; ld_address = '0;
   endtask

   task automatic enq(input logic [31:0] t, input logic [31:0] a, input logic [31:0] d);
      idle(); memwrite = 1; inst_num = t; address = a; store_data = d; step(); idle();
   endtask

   task automatic commit(input logic [31:0] t, input logic [31:0] a);
      idle(); commit_valid = 1; inst_num_rob = t; mem_addr_rob = a; step(); idle();
   endtask

   task automatic query(input logic [31:0] t, input logic [31:0] a);
      idle(); ld_query = 1; ld_inst_num = t; ld_address = a; step(); idle();
   endtask

   task automatic flush_all();
      idle(); exception_sig = 1; step(); idle();
   endtask

   function automatic logic tag_live(input logic [31:0] t);
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_tag[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      logic [31:0] d0, d1;
      int          k, start;
      idle();
      mem_req_ready = 1;
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      compare();
      chk("reset_empty", {31'b0, sb_empty}, 32'd1);
      chk("reset_req", {31'b0, mem_req_valid}, 32'd0);

      // single store commit and drain
      enq(32'd5, 32'h40, 32'hAAAA);
      commit(32'd5, 32'h40);
      step();
      chk("t1_req", {31'b0, mem_req_valid}, 32'd1);
      chk("t1_addr", mem_addr, 32'h40);
      chk("t1_data", mem_wdata, 32'hAAAA);
      step();
      chk("t1_req_done", {31'b0, mem_req_valid}, 32'd0);
      chk("t1_empty", {31'b0, sb_empty}, 32'd1);

      // drain follows tag order
      drained.delete();
      enq(32'd7, 32'h80, 32'h7);
      enq(32'd3, 32'h80, 32'h3);
      commit(32'd3, 32'h80);
      commit(32'd7, 32'h80);
      repeat (8) step();
      d0 = (drained.size() > 0) ? drained[0] : 32'hDEAD;
      d1 = (drained.size() > 1) ? drained[1] : 32'hDEAD;
      chk("t2_count", drained.size(), 32'd2);
      chk("t2_first", d0, 32'h3);
      chk("t2_second", d1, 32'h7);

      // forwarding picks youngest older store
      enq(32'd2, 32'h10, 32'h22);
      enq(32'd4, 32'h10, 32'h44);
      query(32'd6, 32'h10);
      chk("t3_hit6", {31'b0, fwd_hit}, 32'd1);
      chk("t3_data6", fwd_data, 32'h44);
      query(32'd3, 32'h10);
      chk("t3_data3", fwd_data, 32'h22);
      query(32'd1, 32'h10);
      chk("t3_hit1", {31'b0, fwd_hit}, 32'd0);
      flush_all();
      chk("t3_flushed", {31'b0, sb_empty}, 32'd1);

      // flush keeps only the committed store
      drained.delete();
      enq(32'd1, 32'h100, 32'h11);
      enq(32'd2, 32'h104, 32'h22);
      enq(32'd3, 32'h108, 32'h33);
      commit(32'd1, 32'h100);
      flush_all();
      repeat (6) step();
      d0 = (drained.size() > 0) ? drained[0] : 32'hDEAD;
      chk("t4_count", drained.size(), 32'd1);
      chk("t4_data", d0, 32'h11);
      chk("t4_empty", {31'b0, sb_empty}, 32'd1);

      // fill, overflow drop, drain one
      for (int i = 0; i < DEPTH; i++) enq(32'(10 + i), 32'(32'h200 + 4 * i), 32'(i));
      chk("t5_full", {31'b0, sb_full}, 32'd1);
      enq(32'd99, 32'h300, 32'h99);
      chk("t5_still_full", {31'b0, sb_full}, 32'd1);
      query(32'd100, 32'h300);
      chk("t5_dropped", {31'b0, fwd_hit}, 32'd0);
      commit(32'd10, 32'h200);
      repeat (3) step();
      chk("t5_not_full", {31'b0, sb_full}, 32'd0);
      flush_all();
      chk("t5_flushed", {31'b0, sb_empty}, 32'd1);

`ifdef STORE_ADDR_CHECK_EN
      enq(32'd50, 32'd2049, 32'h1);
      chk("t6_exc", {31'b0, store_address_exception}, 32'd1);
      chk("t6_not_alloc", {31'b0, sb_empty}, 32'd1);
      step();
      chk("t6_exc_pulse", {31'b0, store_address_exception}, 32'd0);
      enq(32'd51, 32'd2048, 32'h2);
      chk("t6_accept", {31'b0, sb_empty}, 32'd0);
      flush_all();
`endif

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idle();
         mem_req_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 40) begin
            k = $urandom_range(0, 200);
            if (!tag_live(32'(k))) begin
               memwrite = 1; inst_num = 32'(k);
               address = 32'($urandom_range(0, 7) * 4); store_data = $urandom;
`ifdef STORE_ADDR_CHECK_EN
               if ($urandom_range(0, 9) == 0) address = 32'($urandom_range(2040, 2056));
`endif
            end
         end
         if ($urandom_range(0, 99) < 35) begin
            commit_valid = 1;
            start = $urandom_range(0, DEPTH - 1);
            inst_num_rob = 32'($urandom_range(0, 200));
            mem_addr_rob = 32'($urandom_range(0, 7) * 4);
            if (memwrite && $urandom_range(0, 4) == 0) begin
               inst_num_rob = inst_num; mem_addr_rob = address;
            end else if ($urandom_range(0, 3) != 0) begin
               for (int j = 0; j < DEPTH; j++) begin
                  k = (start + j) % DEPTH;
                  if (m_valid[k] && !m_comm[k]) begin
                     inst_num_rob = m_tag[k]; mem_addr_rob = m_addr[k];
                     break;
                  end
               end
            end
         end
         if ($urandom_range(0, 99) < 40) begin
            ld_query = 1;
            ld_inst_num = 32'($urandom_range(0, 255));
            ld_address = 32'($urandom_range(0, 7) * 4);
         end
         k = $urandom_range(0, 99);
         if (k < 2) exception_sig = 1;
         else if (k < 4) mret_sig = 1;
         if (cyc == 1500) begin
            idle();
            reset = 1;
            @(posedge clk);
            #1 reset = 0;
            model_reset();
            compare();
         end else begin
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
